// File: rtl/mc14516b_timer_ctrl.sv
// mc14516b_timer_ctrl
// Control-side driver for a cascaded chain of MC14516B 4-bit up/down counters
// used as a programmable interval timer. Presets the chain with the interval,
// enables counting, detects terminal count from the readback and issues a
// one-shot or periodic expiry pulse.
//
// Optional feature macro: MC14516B_TIMER_PERIOD_COUNT_EN
//   When defined, adds the periods[7:0] output. It counts TERM cycles, wraps
//   at 255 and is cleared on an accepted start.
//
// Ports:
//   clock              system clock, shared with the counter chain
//   reset              asynchronous active-low reset
//   start              one-cycle arm request, ignored while busy
//   stop               abort, highest priority after reset
//   periodic           1 = auto-reload after expiry, sampled on accepted start
//   count_up           1 = chain counts up, sampled on accepted start
//   load_value[W]      interval N in clock cycles, sampled on accepted start
//   cnt_result[W]      chain readback (stage 0 = LSBs)
//   cnt_carry_out      last-stage carry_out, active-low terminal count
//   cnt_preset[W]      preset bus to the chain
//   cnt_preset_enable  chain preset strobe, active-high
//   cnt_up_down        chain direction
//   cnt_carry_in       first-stage carry_in, 0 = count, 1 = hold
//   busy               high whenever not IDLE
//   done               one-cycle expiry pulse
//   periods[8]         expiry counter (optional feature only)
//   fault              sticky chain-fault flag
module mc14516b_timer_ctrl #(
    parameter int unsigned STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic                  count_up,
    input  logic [4*STAGES-1:0]   load_value,
    input  logic [4*STAGES-1:0]   cnt_result,
    input  logic                  cnt_carry_out,
    output logic [4*STAGES-1:0]   cnt_preset,
    output logic                  cnt_preset_enable,
    output logic                  cnt_up_down,
    output logic                  cnt_carry_in,
    output logic                  busy,
    output logic                  done,
`ifdef MC14516B_TIMER_PERIOD_COUNT_EN
    output logic [7:0]            periods,
`endif
    output logic                  fault
);

    localparam int unsigned W = 4 * STAGES;

    // Value one step before terminal count in each direction
    localparam logic [W-1:0] T1_UP   = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] T1_DOWN = W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        COUNT = 3'd3,
        TERM  = 3'd4
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         periodic_q;
    logic         accept;
    logic [W-1:0] pre_term;
    logic         preset_enable_d;
    logic         carry_in_d;
    logic         busy_d;
    logic         done_d;

    // cnt_up_down doubles as the latched direction
    assign pre_term = cnt_up_down ? T1_UP : T1_DOWN;

    // Next-state and next-output logic
    always_comb begin
        state_d         = state_q;
        accept          = 1'b0;
        preset_enable_d = 1'b0;
        carry_in_d      = 1'b1;
        busy_d          = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD:  state_d = ARM;
            // carry_out already low means N = 0: skip counting entirely
            ARM:   state_d = cnt_carry_out ? COUNT : TERM;
            // Stop on the step that lands on terminal, so the chain never wraps
            COUNT: if (cnt_result == pre_term) state_d = TERM;
            TERM:  state_d = periodic_q ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
        end

        // Outputs are registered images of the state being entered
        preset_enable_d = (state_d == LOAD);
        carry_in_d      = (state_d != COUNT);
        busy_d          = (state_d != IDLE);
        done_d          = (state_d == TERM);
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and latched configuration
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_preset        <= '0;
            cnt_preset_enable <= 1'b0;
            cnt_up_down       <= 1'b0;
            cnt_carry_in      <= 1'b1;
            busy              <= 1'b0;
            done              <= 1'b0;
            fault             <= 1'b0;
            periodic_q        <= 1'b0;
        end else begin
            cnt_preset_enable <= preset_enable_d;
            cnt_carry_in      <= carry_in_d;
            busy              <= busy_d;
            done              <= done_d;
            if (accept) begin
                periodic_q  <= periodic;
                cnt_up_down <= count_up;
                // Up-counting starts N steps below all-ones
                cnt_preset  <= count_up ? ~load_value : load_value;
                fault       <= 1'b0;
            end else if ((state_q == TERM) && cnt_carry_out) begin
                // Chain did not report terminal count where we expected it
                fault <= 1'b1;
            end
        end
    end

`ifdef MC14516B_TIMER_PERIOD_COUNT_EN
    // Expiry counter, wraps naturally at 8 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            periods <= 8'd0;
        end else if (accept) begin
            periods <= 8'd0;
        end else if (state_q == TERM) begin
            periods <= periods + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc14516b_timer_ctrl.sv
// Testbench for mc14516b_timer_ctrl: models the MC14516B chain as a simple
// synchronous up/down counter, runs a table of directed intervals, a few
// hand-written corner sequences, and randomized intervals checked against a
// cycle-offset timeline model.
module tb_mc14516b_timer_ctrl;

    localparam int unsigned STAGES = 2;
    localparam int unsigned W      = 4 * STAGES;
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         stop;
    logic         periodic;
    logic         count_up;
    logic [W-1:0] load_value;
    logic [W-1:0] cnt_result;
    logic         cnt_carry_out;
    logic [W-1:0] cnt_preset;
    logic         cnt_preset_enable;
    logic         cnt_up_down;
    logic         cnt_carry_in;
    logic         busy;
    logic         done;
    logic         fault;
`ifdef MC14516B_TIMER_PERIOD_COUNT_EN
    logic [7:0]   periods;
`endif

    logic [W-1:0] chain = '0;
    logic         force_co = 1'b0;

    mc14516b_timer_ctrl #(.STAGES(STAGES)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .periodic          (periodic),
        .count_up          (count_up),
        .load_value        (load_value),
        .cnt_result        (cnt_result),
        .cnt_carry_out     (cnt_carry_out),
        .cnt_preset        (cnt_preset),
        .cnt_preset_enable (cnt_preset_enable),
        .cnt_up_down       (cnt_up_down),
        .cnt_carry_in      (cnt_carry_in),
        .busy              (busy),
        .done              (done),
`ifdef MC14516B_TIMER_PERIOD_COUNT_EN
        .periods           (periods),
`endif
        .fault             (fault)
    );

    always #5 clock = ~clock;

    // Counter chain: preset wins, otherwise steps when carry_in is low
    assign cnt_result    = chain;
    assign cnt_carry_out = force_co | (chain != (cnt_up_down ? ALL_ONES : '0));

    always @(posedge clock) begin
        if (cnt_preset_enable) begin
            chain <= cnt_preset;
        end else if (!cnt_carry_in) begin
            chain <= cnt_up_down ? chain + W'(1) : chain - W'(1);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic d, input logic pe,
                                         input logic ci, input logic ud, input logic f,
                                         input logic [W-1:0] p);
        return 32'({b, d, pe, ci, ud, f, p});
    endfunction

    function automatic logic [31:0] outs();
        return pack(busy, done, cnt_preset_enable, cnt_carry_in, cnt_up_down, fault, cnt_preset);
    endfunction

    task automatic launch(input logic [W-1:0] n, input logic up, input logic per);
        load_value = n;
        count_up   = up;
        periodic   = per;
        start      = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] n;
        logic         up;
        logic         per;
        int           stop_at;         // 0 = never
        logic         start_with_stop;
        int           run_len;
        int           exp_dones;
        int           exp_first;       // 0 = no done
        logic [W-1:0] exp_preset;
        logic [W-1:0] exp_chain;
    } vec_t;

    vec_t tbl[7];

    int           dones;
    int           first;
    int           r_n;
    int           r_end;
    int           r_stop;
    int           r_run;
    int           r_phase;
    logic         r_up;
    logic         r_per;
    logic [W-1:0] r_p;
    logic [31:0]  r_exp;

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0;
        count_up = 1'b0; load_value = '0;

        //           n      up    per   stop st   run  dn first preset  chain
        tbl[0] = '{8'd5,   1'b0, 1'b0, 0,   1'b0, 12,  1, 8,    8'h05, 8'h00};
        tbl[1] = '{8'd3,   1'b1, 1'b1, 18,  1'b0, 20,  3, 6,    8'hFC, 8'hFF};
        tbl[2] = '{8'd0,   1'b0, 1'b0, 0,   1'b0, 6,   1, 3,    8'h00, 8'h00};
        tbl[3] = '{8'd10,  1'b0, 1'b0, 4,   1'b1, 16,  0, 0,    8'h0A, 8'h08};
        tbl[4] = '{8'd1,   1'b1, 1'b0, 0,   1'b0, 8,   1, 4,    8'hFE, 8'hFF};
        tbl[5] = '{8'd255, 1'b0, 1'b0, 0,   1'b0, 262, 1, 258,  8'hFF, 8'h00};
        tbl[6] = '{8'd0,   1'b1, 1'b0, 0,   1'b0, 6,   1, 3,    8'hFF, 8'hFF};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outs", outs(), pack(0, 0, 0, 1, 0, 0, 8'h00));
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", outs(), pack(0, 0, 0, 1, 0, 0, 8'h00));

        // Directed intervals
        for (int i = 0; i < 7; i++) begin
            dones = 0;
            first = 0;
            launch(tbl[i].n, tbl[i].up, tbl[i].per);
            for (int t = 1; t <= tbl[i].run_len; t++) begin
                @(negedge clock);
                start = 1'b0;
                stop  = 1'b0;
                if (done) begin
                    dones++;
                    if (first == 0) first = t;
                end
                if (t == 1)
                    check($sformatf("v%0d_load", i), 32'({cnt_preset_enable, cnt_preset}),
                          32'({1'b1, tbl[i].exp_preset}));
                if (t == tbl[i].stop_at) begin
                    stop = 1'b1;
                    if (tbl[i].start_with_stop) begin
                        start      = 1'b1;
                        load_value = 8'h33;
                        count_up   = ~tbl[i].up;
                    end
                end
            end
            check($sformatf("v%0d_dones", i), 32'(dones), 32'(tbl[i].exp_dones));
            check($sformatf("v%0d_first_done", i), 32'(first), 32'(tbl[i].exp_first));
            check($sformatf("v%0d_chain", i), 32'(chain), 32'(tbl[i].exp_chain));
            check($sformatf("v%0d_end_outs", i), outs(),
                  pack(0, 0, 0, 1, tbl[i].up, 0, tbl[i].exp_preset));
`ifdef MC14516B_TIMER_PERIOD_COUNT_EN
            if (i == 1) check("v1_periods", 32'(periods), 32'd3);
`endif
        end

        // Chain disagrees at TERM: fault sets, sticks, and clears on next start
        launch(8'd4, 1'b0, 1'b0);
        force_co = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clock);
            start = 1'b0;
            if (t == 7) check("flt_done", 32'(done), 32'd1);
            if (t == 8) check("flt_set", 32'(fault), 32'd1);
        end
        check("flt_sticky", 32'(fault), 32'd1);
        force_co = 1'b0;
        launch(8'd2, 1'b0, 1'b0);
        @(negedge clock);
        start = 1'b0;
        check("flt_clear", 32'(fault), 32'd0);
        repeat (6) @(negedge clock);
        check("flt_idle", outs(), pack(0, 0, 0, 1, 0, 0, 8'h02));

        // Asynchronous reset in the middle of COUNT (N = 20, down)
        launch(8'd20, 1'b0, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            @(negedge clock);
            start = 1'b0;
        end
        #1 reset = 1'b0;
        #1;
        check("rst_async_outs", outs(), pack(0, 0, 0, 1, 0, 0, 8'h00));
        check("rst_chain", 32'(chain), 32'd17);
        repeat (3) @(negedge clock);
        check("rst_chain_frozen", 32'(chain), 32'd17);
        reset = 1'b1;
        @(negedge clock);
        check("rst_release", outs(), pack(0, 0, 0, 1, 0, 0, 8'h00));

        // Randomized intervals against a cycle-offset timeline
        for (int k = 0; k < 30; k++) begin
            r_n   = int'($urandom_range(0, 12));
            r_up  = 1'($urandom_range(0, 1));
            r_per = 1'($urandom_range(0, 1));
            r_p   = r_up ? ~W'(r_n) : W'(r_n);
            if (r_per) r_stop = int'($urandom_range(1, 3 * (r_n + 3)));
            else if ($urandom_range(0, 1) == 1) r_stop = int'($urandom_range(1, r_n + 5));
            else r_stop = 0;
            r_end = r_per ? 1000000 : r_n + 3;
            if (r_stop != 0 && r_stop < r_end) r_end = r_stop;
            r_run = r_end + 3;
            launch(W'(r_n), r_up, r_per);
            for (int t = 1; t <= r_run; t++) begin
                @(negedge clock);
                start = 1'b0;
                stop  = 1'b0;
                if (t > r_end) begin
                    r_exp = pack(0, 0, 0, 1, r_up, 0, r_p);
                end else begin
                    r_phase = (t - 1) % (r_n + 3);
                    r_exp = pack(1, r_phase == r_n + 2, r_phase == 0,
                                 !(r_phase >= 2 && r_phase <= r_n + 1), r_up, 0, r_p);
                    if (r_phase == r_n + 2)
                        check("rnd_term_chain", 32'(chain), 32'(r_up ? ALL_ONES : '0));
                end
                check($sformatf("rnd%0d_t%0d", k, t), outs(), r_exp);
                if (t == r_stop && t < r_run) stop = 1'b1;
                if (t <= r_end && $urandom_range(0, 7) == 0) begin
                    start      = 1'b1;
                    load_value = W'($urandom);
                    count_up   = 1'($urandom);
                    periodic   = 1'($urandom);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc14516b_timer_ctrl.md
Name: mc14516b_timer_ctrl

Overview:
Control-side driver for a cascaded chain of MC14516B 4-bit up/down counters used as a programmable interval timer.
- Drives the chain's preset, preset_enable, up_down and carry_in inputs.
- Reads back the chain value and the final-stage carry_out to detect terminal count.
- Issues a one-shot or periodic expiry pulse to the MC14500B-side control logic.

Parameters:
STAGES, 2, number of cascaded 4-bit counter stages; chain width W = 4*STAGES.

Ports:
clock  in  1  system clock, shared with the counter chain
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to arm the timer; ignored while busy
stop  in  1  abort; highest priority after reset
periodic  in  1  1 = auto-reload after expiry, 0 = one-shot; sampled on accepted start
count_up  in  1  1 = chain counts up, 0 = down; sampled on accepted start
load_value  in  W  interval N in clock cycles; sampled on accepted start
cnt_result  in  W  chain value readback (concatenated stage results, stage 0 = LSBs)
cnt_carry_out  in  1  last-stage carry_out; active-low terminal count
cnt_preset  out  W  preset bus to chain
cnt_preset_enable  out  1  chain preset strobe, active-high
cnt_up_down  out  1  chain direction
cnt_carry_in  out  1  first-stage carry_in; 0 = count enabled, 1 = hold
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle expiry pulse
fault  out  1  sticky chain-fault flag

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE
  - cnt_preset = 0, cnt_preset_enable = 0, cnt_up_down = 0, cnt_carry_in = 1
  - busy = 0, done = 0, fault = 0
  - latched mode, direction and value = 0
- Latched preset: P = count_up ? ~load_value : load_value.
- Terminal value: T = count_up ? all-ones : 0.
- Pre-terminal value: T1 = count_up ? all-ones minus 1 : 1.
- IDLE:
  - cnt_carry_in = 1, cnt_preset_enable = 0.
  - start = 1 and stop = 0: latch periodic, count_up and P; clear fault; go to LOAD.
- LOAD (1 cycle):
  - cnt_preset = P, cnt_preset_enable = 1, cnt_carry_in = 1, cnt_up_down = latched direction.
  - Next state: ARM.
- ARM (1 cycle):
  - cnt_preset_enable = 0, cnt_carry_in = 1.
  - cnt_carry_out = 0 (N = 0): go to TERM, no counting.
  - Otherwise: set cnt_carry_in = 0 and go to COUNT.
- COUNT:
  - cnt_carry_in = 0; the chain steps once per clock.
  - On an edge where cnt_result == T1: register cnt_carry_in = 1 and go to TERM. The chain lands on T and holds.
  - Result: exactly N chain steps for N >= 1.
- TERM (1 cycle):
  - done = 1.
  - cnt_carry_out = 1: set fault, because the chain disagrees with the readback.
  - Next state: LOAD if periodic, else IDLE.
- Period timing:
  - Periodic mode repeats every N+3 cycles: LOAD + ARM + N COUNT + TERM.
  - One-shot mode: done occurs N+3 cycles after start is accepted.
- Reload: periodic reload reuses the latched P. load_value changes take effect only on the next accepted start.
- stop:
  - In any state, the next state is IDLE and cnt_carry_in = 1 on the next edge.
  - cnt_preset_enable is forced to 0 and done is not pulsed.
  - stop and start together: stop wins.
- start while busy: ignored; no re-latch.
- Wrap-around: not permitted in COUNT. cnt_carry_in is deasserted before the chain passes T.
- Reset mid-operation: asynchronous return to reset values. The chain holds because cnt_carry_in = 1.

Optional Feature:
- Macro: MC14516B_TIMER_PERIOD_COUNT_EN.
- Defined:
  - Adds output port periods[7:0], reset to 0.
  - Increments in each TERM cycle and wraps 255 -> 0.
  - Cleared on an accepted start.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset low mid-COUNT (N = 20, down) -> all outputs at reset values immediately; cnt_carry_in = 1; chain value frozen.
- Down one-shot, N = 5, STAGES = 2 -> LOAD drives cnt_preset = 0x05 with strobe; done one cycle at start+8; chain holds 0x00; busy falls the cycle after done; fault = 0.
- Up periodic, N = 3 -> cnt_preset = 0xFC; done every 6 cycles; chain holds 0xFF at each TERM; three consecutive pulses observed; with the macro, periods = 3.
- N = 0, down -> ARM sees cnt_carry_out = 0; zero COUNT cycles; done at start+3.
- stop asserted on the 2nd COUNT cycle of N = 10 -> next cycle IDLE, cnt_carry_in = 1, no done; a start in the same cycle as stop is ignored.
- Chain model forcing cnt_carry_out = 1 at TERM, N = 4 -> done pulses and fault sets and stays set; the next accepted start clears fault.
